vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 143 ++++++++++++++
 tb/tb_vram_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetches on fixed slots take absolute priority; CPU accesses
// are granted in free decision cycles and acknowledged after their data/issue cycle.
module vram_arbiter #(
    parameter int unsigned CONTEND = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [3:0]  slot,
    input  logic        paper,
    input  logic [12:0] bmp_addr,
    input  logic [12:0] att_addr,
    output logic [7:0]  vid_data,
    output logic        vid_bmp_stb,
    output logic        vid_att_stb,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [12:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_wait,
    output logic [12:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] stall_cnt
);

    localparam bit ContendEn = (CONTEND != 0);

    typedef enum logic [1:0] {StIdle, StCpuRd, StCpuWr, StCpuAck} state_e;

    state_e      state_q, state_d;
    logic        rd_phase_q, rd_phase_d;
    logic [1:0]  vid1_q, vid1_d;  // {valid, is_attribute} for the issue cycle
    logic [1:0]  vid2_q;          // same, for the data cycle
    logic [7:0]  vid_data_q, vid_data_d;
    logic        bmp_stb_q, bmp_stb_d;
    logic        att_stb_q, att_stb_d;
    logic [7:0]  cpu_rdata_q, cpu_rdata_d;
    logic [12:0] mem_addr_q, mem_addr_d;
    logic        mem_we_q, mem_we_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic [15:0] stall_q, stall_d;

    logic video_dec;
    logic cpu_block;
    logic grant;

    assign video_dec = paper && slot[3] && !slot[0];
    assign cpu_block = video_dec || (ContendEn && paper && slot[3]);
    assign grant     = (state_q == StIdle) && cpu_req && !cpu_block;

    always_comb begin
        state_d     = state_q;
        rd_phase_d  = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;

        // Video and CPU never both decide in one cycle: grant excludes video decisions.
        if (video_dec) begin
            mem_addr_d = slot[1] ? att_addr : bmp_addr;
        end

        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    mem_addr_d = cpu_addr;
                    mem_we_d   = cpu_we;
                    if (cpu_we) begin
                        mem_wdata_d = cpu_wdata;
                        state_d     = StCpuWr;
                    end else begin
                        state_d = StCpuRd;
                    end
                end
            end
            StCpuRd: begin
                if (rd_phase_q) begin
                    cpu_rdata_d = mem_rdata;
                    state_d     = StCpuAck;
                end else begin
                    rd_phase_d = 1'b1;
                end
            end
            StCpuWr:  state_d = StCpuAck;
            StCpuAck: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        vid1_d     = {video_dec, slot[1]};
        bmp_stb_d  = vid2_q[1] && !vid2_q[0];
        att_stb_d  = vid2_q[1] && vid2_q[0];
        vid_data_d = vid2_q[1] ? mem_rdata : vid_data_q;
        stall_d    = (cpu_wait && (stall_q != 16'hFFFF)) ? stall_q + 16'd1 : stall_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= StIdle;
            rd_phase_q  <= 1'b0;
            vid1_q      <= 2'b00;
            vid2_q      <= 2'b00;
            vid_data_q  <= 8'h00;
            bmp_stb_q   <= 1'b0;
            att_stb_q   <= 1'b0;
            cpu_rdata_q <= 8'h00;
            mem_addr_q  <= 13'h0000;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 8'h00;
            stall_q     <= 16'h0000;
        end else begin
            state_q     <= state_d;
            rd_phase_q  <= rd_phase_d;
            vid1_q      <= vid1_d;
            vid2_q      <= vid1_q;
            vid_data_q  <= vid_data_d;
            bmp_stb_q   <= bmp_stb_d;
            att_stb_q   <= att_stb_d;
            cpu_rdata_q <= cpu_rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            stall_q     <= stall_d;
        end
    end

    assign vid_data    = vid_data_q;
    assign vid_bmp_stb = bmp_stb_q;
    assign vid_att_stb = att_stb_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign cpu_ack     = (state_q == StCpuAck);
    assign cpu_wait    = cpu_req && (state_q != StCpuAck);
    assign mem_addr    = mem_addr_q;
    assign mem_we      = mem_we_q;
    assign mem_wdata   = mem_wdata_q;
    assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: table of CPU transactions plus hand sequences, with an event
// scoreboard for strobes/acks and per-cycle checks of the memory port and stall counter.
module tb_vram_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [3:0]  slot;
    logic        paper;
    logic [12:0] bmp_addr, att_addr;
    logic        cpu_req, cpu_req0, cpu_we;
    logic [12:0] cpu_addr;
    logic [7:0]  cpu_wdata;

    logic [7:0]  vid_data, cpu_rdata, mem_wdata, mem_rdata;
    logic        vid_bmp_stb, vid_att_stb, cpu_ack, cpu_wait, mem_we;
    logic [12:0] mem_addr;
    logic [15:0] stall_cnt;

    logic [7:0]  vid_data0, cpu_rdata0, mem_wdata0, mem_rdata0;
    logic        vid_bmp_stb0, vid_att_stb0, cpu_ack0, cpu_wait0, mem_we0;
    logic [12:0] mem_addr0;
    logic [15:0] stall_cnt0;

    always #5 CLK = ~CLK;

    vram_arbiter #(.CONTEND(1)) u_dut (
        .CLK(CLK), .RESET(RESET), .slot(slot), .paper(paper),
        .bmp_addr(bmp_addr), .att_addr(att_addr),
        .vid_data(vid_data), .vid_bmp_stb(vid_bmp_stb), .vid_att_stb(vid_att_stb),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall_cnt(stall_cnt)
    );

    vram_arbiter #(.CONTEND(0)) u_dut0 (
        .CLK(CLK), .RESET(RESET), .slot(slot), .paper(paper),
        .bmp_addr(bmp_addr), .att_addr(att_addr),
        .vid_data(vid_data0), .vid_bmp_stb(vid_bmp_stb0), .vid_att_stb(vid_att_stb0),
        .cpu_req(cpu_req0), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata0), .cpu_ack(cpu_ack0), .cpu_wait(cpu_wait0),
        .mem_addr(mem_addr0), .mem_we(mem_we0), .mem_wdata(mem_wdata0),
        .mem_rdata(mem_rdata0), .stall_cnt(stall_cnt0)
    );

    function automatic logic [7:0] pat(input logic [12:0] a);
        return a[7:0] ^ {3'b000, a[12:8]} ^ 8'h3C;
    endfunction

    logic [7:0] mem [8192];
    logic [7:0] ref_mem [8192];

    // VRAM model: read data valid the cycle after the address
    always @(posedge CLK) begin
        mem_rdata <= mem[mem_addr];
        if (mem_we === 1'b1) mem[mem_addr] = mem_wdata;
    end

    always @(posedge CLK) mem_rdata0 <= pat(mem_addr0);

    typedef struct {
        int         cyc;
        int         kind;  // 0 bitmap strobe, 1 attribute strobe, 2 cpu ack
        logic [7:0] data;
    } ev_t;

    typedef struct {
        logic [3:0]  slot;
        logic        paper;
        logic        we;
        logic [12:0] addr;
        logic [7:0]  wdata;
        int          delay;
        logic [7:0]  rdata;
    } vec_t;

    ev_t         sb[$];
    vec_t        vecs[10];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    bit          run_hc = 1'b1;
    int          cpu_ack_cyc = -1;
    int          cpu_iss_cyc = -1;
    logic        cpu_iss_we;
    logic [12:0] cpu_iss_addr;
    logic [7:0]  cpu_iss_wdata;
    int          vis_cyc = -1;
    logic [12:0] vis_addr;
    logic [15:0] exp_stall = 16'h0;
    logic [7:0]  last_rd = 8'h00;
    int          bmp_cnt = 0;
    int          att_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_event(input logic seen, input int kind, input logic [7:0] data);
        int idx = -1;
        if (seen === 1'b0) return;
        for (int i = 0; i < sb.size(); i++)
            if (sb[i].cyc == cyc && sb[i].kind == kind) idx = i;
        checks++;
        if (idx < 0) begin
            failures++;
            $display("FAIL unexpected_event kind=%0d cycle=%0d actual=1 required=0", kind, cyc);
        end else begin
            if (data !== sb[idx].data) begin
                failures++;
                $display("FAIL event_data kind=%0d cycle=%0d actual=%0h required=%0h",
                         kind, cyc, data, sb[idx].data);
            end
            sb.delete(idx);
        end
    endtask

    // Per-cycle monitor and reference model for the contended instance
    always @(negedge CLK) begin
        if (mon_en) begin
            logic exp_wait;
            if (vid_bmp_stb === 1'b1) bmp_cnt++;
            if (vid_att_stb === 1'b1) att_cnt++;
            chk_event(vid_bmp_stb, 0, vid_data);
            chk_event(vid_att_stb, 1, vid_data);
            chk_event(cpu_ack, 2, cpu_rdata);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc <= cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL missing_event kind=%0d due=%0d actual=absent required=%0h",
                             sb[i].kind, sb[i].cyc, sb[i].data);
                    sb.delete(i);
                end else if (RESET) begin
                    sb.delete(i);
                end
            end
            check("mem_we", mem_we, (cyc == cpu_iss_cyc) && cpu_iss_we);
            if (cyc == cpu_iss_cyc) begin
                check("cpu_issue_addr", mem_addr, cpu_iss_addr);
                if (cpu_iss_we) check("cpu_issue_wdata", mem_wdata, cpu_iss_wdata);
            end
            if (cyc == vis_cyc) check("video_issue_addr", mem_addr, vis_addr);
            exp_wait = cpu_req && (cyc != cpu_ack_cyc);
            check("cpu_wait", cpu_wait, exp_wait);
            check("stall_cnt", stall_cnt, exp_stall);
            if (RESET) exp_stall = 16'h0;
            else if (exp_wait && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
            if (!RESET && paper && slot[3] && !slot[0]) begin
                vis_cyc  = cyc + 1;
                vis_addr = slot[1] ? att_addr : bmp_addr;
                sb.push_back('{cyc + 3, slot[1] ? 1 : 0, ref_mem[vis_addr]});
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
        if (run_hc) slot = slot + 4'd1;
    endtask

    task automatic align(input logic [3:0] s);
        while (slot != s) tick();
    endtask

    task automatic cpu_start(input logic we, input logic [12:0] addr, input logic [7:0] wdata,
                             input int delay, input logic [7:0] exp_rdata);
        int d;
        cpu_req       = 1'b1;
        cpu_we        = we;
        cpu_addr      = addr;
        cpu_wdata     = wdata;
        d             = cyc + delay;
        cpu_iss_cyc   = d + 1;
        cpu_iss_we    = we;
        cpu_iss_addr  = addr;
        cpu_iss_wdata = wdata;
        cpu_ack_cyc   = d + (we ? 2 : 3);
        sb.push_back('{cpu_ack_cyc, 2, we ? last_rd : exp_rdata});
        if (we) ref_mem[addr] = wdata;
        else last_rd = exp_rdata;
    endtask

    task automatic cpu_finish();
        while (cyc < cpu_iss_cyc) tick();
        // Disturb the request fields after grant; the latched copy must be used
        cpu_addr  = ~cpu_addr;
        cpu_wdata = ~cpu_wdata;
        cpu_we    = ~cpu_we;
        while (cyc < cpu_ack_cyc) tick();
        tick();
        cpu_req = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; slot = 4'd0; paper = 1'b0;
        bmp_addr = 13'h0010; att_addr = 13'h1802;
        cpu_req = 1'b0; cpu_req0 = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        for (int i = 0; i < 8192; i++) begin
            mem[i]     = pat(i[12:0]);
            ref_mem[i] = pat(i[12:0]);
        end
        mem[13'h0123]     = 8'h5A;
        ref_mem[13'h0123] = 8'h5A;

        vecs[0] = '{4'd3,  1'b0, 1'b0, 13'h0123, 8'h00, 0, 8'h5A};
        vecs[1] = '{4'd5,  1'b0, 1'b1, 13'h0456, 8'hC3, 0, 8'h00};
        vecs[2] = '{4'd7,  1'b0, 1'b0, 13'h0456, 8'h00, 0, 8'hC3};
        vecs[3] = '{4'd9,  1'b1, 1'b1, 13'h1FFF, 8'h81, 7, 8'h00};
        vecs[4] = '{4'd0,  1'b1, 1'b0, 13'h1FFF, 8'h00, 0, 8'h81};
        vecs[5] = '{4'd15, 1'b0, 1'b0, 13'h0000, 8'h00, 0, 8'h3C};
        vecs[6] = '{4'd8,  1'b0, 1'b0, 13'h1ABC, 8'h00, 0, 8'h9A};
        vecs[7] = '{4'd12, 1'b1, 1'b1, 13'h0777, 8'h77, 4, 8'h00};
        vecs[8] = '{4'd1,  1'b1, 1'b0, 13'h0777, 8'h00, 0, 8'h77};
        vecs[9] = '{4'd11, 1'b1, 1'b0, 13'h0123, 8'h00, 5, 8'h5A};

        tick();
        mon_en = 1'b1;
        @(negedge CLK);
        check("rst_vid_data", vid_data, 8'h00);
        check("rst_cpu_rdata", cpu_rdata, 8'h00);
        check("rst_mem_addr", mem_addr, 13'h0000);
        check("rst_mem_wdata", mem_wdata, 8'h00);
        check("rst_cpu_ack", cpu_ack, 1'b0);
        check("rst_strobes", {vid_bmp_stb, vid_att_stb}, 2'b00);
        tick();
        RESET = 1'b0;
        repeat (3) tick();

        for (int v = 0; v < 10; v++) begin
            align(vecs[v].slot);
            paper = vecs[v].paper;
            cpu_start(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].delay, vecs[v].rdata);
            cpu_finish();
            paper = 1'b0;
            repeat (2) tick();
        end

        // Full paper line: two bitmap and two attribute fetches
        align(4'd0);
        bmp_cnt = 0;
        att_cnt = 0;
        paper = 1'b1;
        repeat (16) tick();
        paper = 1'b0;
        repeat (5) tick();
        check("line_bmp_count", bmp_cnt, 2);
        check("line_att_count", att_cnt, 2);

        // Uncontended instance: CPU read requested on a bitmap slot
        align(4'd8);
        paper    = 1'b1;
        cpu_req0 = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 13'h0ABC;
        tick();
        @(negedge CLK);
        check("nc_video_issue", mem_addr0, 13'h0010);
        check("nc_ack_early1", cpu_ack0, 1'b0);
        tick();
        @(negedge CLK);
        check("nc_cpu_issue", mem_addr0, 13'h0ABC);
        check("nc_mem_we", mem_we0, 1'b0);
        tick();
        @(negedge CLK);
        check("nc_bmp_stb", vid_bmp_stb0, 1'b1);
        check("nc_vid_data", vid_data0, pat(13'h0010));
        check("nc_ack_early2", cpu_ack0, 1'b0);
        check("nc_att_issue", mem_addr0, 13'h1802);
        tick();
        @(negedge CLK);
        check("nc_cpu_ack", cpu_ack0, 1'b1);
        check("nc_cpu_rdata", cpu_rdata0, pat(13'h0ABC));
        check("nc_bmp_stb_once", vid_bmp_stb0, 1'b0);
        tick();
        cpu_req0 = 1'b0;
        paper    = 1'b0;
        repeat (4) tick();

        // Reset during the data cycle of a CPU read, request held across reset
        align(4'd3);
        cpu_start(1'b0, 13'h0555, 8'h00, 0, pat(13'h0555));
        tick();
        tick();
        RESET       = 1'b1;
        cpu_ack_cyc = -1;
        last_rd     = 8'h00;
        tick();
        @(negedge CLK);
        check("rr_cpu_ack", cpu_ack, 1'b0);
        check("rr_cpu_rdata", cpu_rdata, 8'h00);
        check("rr_vid_data", vid_data, 8'h00);
        check("rr_mem_addr", mem_addr, 13'h0000);
        check("rr_mem_wdata", mem_wdata, 8'h00);
        tick();
        RESET = 1'b0;
        cpu_start(1'b0, 13'h0555, 8'h00, 0, pat(13'h0555));
        cpu_finish();
        repeat (2) tick();

        // Permanent contention: stall counter must saturate
        paper   = 1'b1;
        run_hc  = 1'b0;
        slot    = 4'd9;
        cpu_req = 1'b1;
        repeat (70000) tick();
        @(negedge CLK);
        check("stall_saturated", stall_cnt, 16'hFFFF);
        tick();
        cpu_req = 1'b0;
        paper   = 1'b0;
        run_hc  = 1'b1;
        repeat (10) tick();
        check("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
